// File: rtl/minmax_scan.sv
// rtl/minmax_scan.sv - burst min/max/count scanner sharing one external less-than comparator
// Optional MINMAX_SIGNED_EN: two's complement ordering via MSB inversion on cmp_a/cmp_b.
module minmax_scan #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {ACCEPT, CMP_MIN, CMP_MAX, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, next_state;
  logic             first;
  logic             hold_last;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] op_a, op_b;
  logic             take;

  assign take = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCEPT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ACCEPT:  if (take) next_state = first ? (in_last ? DONE : ACCEPT) : CMP_MIN;
      CMP_MIN: next_state = CMP_MAX;
      CMP_MAX: next_state = hold_last ? DONE : ACCEPT;
      DONE:    if (out_ready) next_state = ACCEPT;
      default: next_state = ACCEPT;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCEPT);
    out_valid = (state == DONE);
  end

  // Operand registers feed the comparator; its result is consumed the cycle after loading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first     <= 1'b1;
      hold      <= '0;
      hold_last <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ACCEPT: begin
          if (take) begin
            if (first) begin
              out_min   <= in_data;
              out_max   <= in_data;
              out_count <= CNT_W'(1);
              first     <= 1'b0;
            end else begin
              hold      <= in_data;
              hold_last <= in_last;
              if (out_count != CNT_MAX) out_count <= out_count + CNT_W'(1);
              op_a      <= in_data;
              op_b      <= out_min;
            end
          end
        end
        CMP_MIN: begin
          if (cmp_lt) out_min <= hold;
          op_a <= out_max;
          op_b <= hold;
        end
        CMP_MAX: begin
          if (cmp_lt) out_max <= hold;
          op_a <= '0;
          op_b <= '0;
        end
        DONE: begin
          if (out_ready) first <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MINMAX_SIGNED_EN
  localparam logic [WIDTH-1:0] MSB_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
  assign cmp_a = op_a ^ MSB_FLIP;
  assign cmp_b = op_b ^ MSB_FLIP;
`else
  assign cmp_a = op_a;
  assign cmp_b = op_b;
`endif

endmodule

// File: tb/tb_minmax_scan.sv
// tb/tb_minmax_scan.sv - self-checking bench for minmax_scan against a queue-based reference model
module tb_minmax_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, cmp_lt;
  logic [31:0] cmp_a, cmp_b, out_min, out_max;
  logic [15:0] out_count;

  logic        in_ready2, out_valid2, cmp_lt2;
  logic [31:0] cmp_a2, cmp_b2, out_min2, out_max2;
  logic [1:0]  out_count2;

  int tests = 0;
  int fails = 0;
  logic [31:0] vals[$];

`ifdef MINMAX_SIGNED_EN
  localparam logic [31:0] FLIP = 32'h8000_0000;
`else
  localparam logic [31:0] FLIP = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  assign cmp_lt  = cmp_a < cmp_b;
  assign cmp_lt2 = cmp_a2 < cmp_b2;

  minmax_scan dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lt(cmp_lt), .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_count(out_count)
  );

  minmax_scan #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .cmp_a(cmp_a2), .cmp_b(cmp_b2),
    .cmp_lt(cmp_lt2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_min(out_min2), .out_max(out_max2), .out_count(out_count2)
  );

  function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
`ifdef MINMAX_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  function automatic void model(input int cmax, output logic [31:0] mn,
                                output logic [31:0] mx, output int cnt);
    mn = vals[0];
    mx = vals[0];
    foreach (vals[i]) begin
      if (ref_lt(vals[i], mn)) mn = vals[i];
      if (ref_lt(mx, vals[i])) mx = vals[i];
    end
    cnt = (vals.size() > cmax) ? cmax : vals.size();
  endfunction

  task automatic send_one(input logic [31:0] d, input logic last, output logic ok);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Returns cycles from the last handshake to out_valid (-1 on timeout) and CMP cycles with in_ready high.
  task automatic drive_burst(output int lat, output int ready_bad);
    logic ok;
    ready_bad = 0;
    lat = -1;
    for (int i = 0; i < vals.size(); i++) begin
      send_one(vals[i], i == vals.size() - 1, ok);
      if (!ok) return;
      if (i == vals.size() - 1) break;
      if (i > 0) repeat (2) begin
        @(negedge clk);
        if (in_ready) ready_bad++;
      end
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat <= 2 && vals.size() > 1 && in_ready) ready_bad++;
    end while (!out_valid && lat < 20);
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tests++;
    if (out_min !== 32'd0 || out_max !== 32'd0 || out_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_res: min=%h max=%h cnt=%0d want 0 0 0", out_min, out_max, out_count);
    end
    tests++;
    if (cmp_a !== FLIP || cmp_b !== FLIP) begin
      fails++;
      $display("FAIL reset_cmp: a=%h b=%h want %h", cmp_a, cmp_b, FLIP);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int lat, rb;
    vals = '{32'h42};
    out_ready = 1'b1;
    drive_burst(lat, rb);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL single_lat: got %0d want 1", lat);
    end
    tests++;
    if (out_min !== 32'h42 || out_max !== 32'h42 || out_count !== 16'd1) begin
      fails++;
      $display("FAIL single_res: min=%h max=%h cnt=%0d want 42 42 1", out_min, out_max, out_count);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_consume: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_burst();
    int lat, rb;
    vals = '{32'd5, 32'd3, 32'd9, 32'd3, 32'd7};
    drive_burst(lat, rb);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL burst_lat: got %0d want 3", lat);
    end
    tests++;
    if (rb !== 0) begin
      fails++;
      $display("FAIL burst_ready: in_ready high in %0d compare cycles want 0", rb);
    end
    tests++;
    if (out_min !== 32'd3 || out_max !== 32'd9 || out_count !== 16'd5) begin
      fails++;
      $display("FAIL burst_res: min=%0d max=%0d cnt=%0d want 3 9 5", out_min, out_max, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    logic ok;
    logic [31:0] emin, emax;
    int lat, rb;
`ifdef MINMAX_SIGNED_EN
    emin = 32'h8000_0000;
    emax = 32'h7FFF_FFFF;
`else
    emin = 32'h7FFF_FFFF;
    emax = 32'h8000_0000;
`endif
    send_one(32'h7FFF_FFFF, 1'b0, ok);
    send_one(32'h8000_0000, 1'b1, ok);
    tests++;
    if (cmp_a !== (32'h8000_0000 ^ FLIP) || cmp_b !== (32'h7FFF_FFFF ^ FLIP)) begin
      fails++;
      $display("FAIL wrap_cmp: a=%h b=%h want %h %h", cmp_a, cmp_b,
               32'h8000_0000 ^ FLIP, 32'h7FFF_FFFF ^ FLIP);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (out_valid !== 1'b1 || out_min !== emin || out_max !== emax || out_count !== 16'd2) begin
      fails++;
      $display("FAIL wrap_res: v=%b min=%h max=%h cnt=%0d want 1 %h %h 2",
               out_valid, out_min, out_max, out_count, emin, emax);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat, rb, bad;
    logic [31:0] smin, smax;
    logic [15:0] scnt;
    vals = '{32'd8, 32'd2, 32'd5};
    out_ready = 1'b0;
    drive_burst(lat, rb);
    smin = 32'd2;
    smax = 32'd8;
    scnt = 16'd3;
    bad = 0;
    repeat (10) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_min !== smin ||
          out_max !== smax || out_count !== scnt) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL hold_stable: %0d bad cycles want 0 (min=%0d max=%0d cnt=%0d)",
               bad, out_min, out_max, out_count);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    vals = '{32'd1, 32'd2};
    drive_burst(lat, rb);
    tests++;
    if (out_min !== 32'd1 || out_max !== 32'd2 || out_count !== 16'd2) begin
      fails++;
      $display("FAIL hold_next: min=%0d max=%0d cnt=%0d want 1 2 2", out_min, out_max, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    logic ok;
    int lat, rb;
    send_one(32'd10, 1'b0, ok);
    send_one(32'd20, 1'b0, ok);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 16'd0) begin
      fails++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b cnt=%0d want 1 0 0",
               in_ready, out_valid, out_count);
    end
    vals = '{32'd4};
    drive_burst(lat, rb);
    tests++;
    if (lat !== 1 || out_count !== 16'd1 || out_min !== 32'd4 || out_max !== 32'd4) begin
      fails++;
      $display("FAIL midrst_next: lat=%0d cnt=%0d min=%0d max=%0d want 1 1 4 4",
               lat, out_count, out_min, out_max);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    int lat, rb;
    vals = {};
    repeat (6) vals.push_back(32'h10);
    drive_burst(lat, rb);
    tests++;
    if (out_valid2 !== 1'b1 || out_count2 !== 2'd3 || out_min2 !== 32'h10 || out_max2 !== 32'h10) begin
      fails++;
      $display("FAIL sat_small: v=%b cnt=%0d min=%h max=%h want 1 3 10 10",
               out_valid2, out_count2, out_min2, out_max2);
    end
    tests++;
    if (out_count !== 16'd6 || out_min !== 32'h10 || out_max !== 32'h10) begin
      fails++;
      $display("FAIL sat_wide: cnt=%0d min=%h max=%h want 6 10 10", out_count, out_min, out_max);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int lat, rb, n, ecnt;
    logic [31:0] emin, emax;
    for (int b = 0; b < 10; b++) begin
      vals = {};
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++)
        vals.push_back(($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3));
      model(65535, emin, emax, ecnt);
      out_ready = ($urandom_range(0, 1) != 0);
      drive_burst(lat, rb);
      tests++;
      if (lat !== ((n == 1) ? 1 : 3) || rb !== 0 || out_min !== emin ||
          out_max !== emax || out_count !== 16'(ecnt)) begin
        fails++;
        $display("FAIL rand_%0d: lat=%0d rb=%0d min=%h max=%h cnt=%0d want min=%h max=%h cnt=%0d",
                 b, lat, rb, out_min, out_max, out_count, emin, emax, ecnt);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_backpressure();
    test_mid_reset();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/minmax_scan.md
Name: minmax_scan

Overview:
- Sequential scanner that accepts a burst of 32-bit operands over a valid/ready stream and reports the minimum, maximum and element count of the burst.
- Does not compare internally: it time-multiplexes one external 32-bit less-than comparator.
- Drives that comparator's a/b inputs from registers and consumes its single-bit result, so the block sits on both sides of the comparator.

Parameters:
WIDTH, 32, operand width; must match the comparator width.
CNT_W, 16, width of the element counter.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input element valid
in_ready  output  1  block can accept an element
in_data  input  WIDTH  element value
in_last  input  1  element is the last of its burst
cmp_a  output  WIDTH  comparator operand a (registered)
cmp_b  output  WIDTH  comparator operand b (registered)
cmp_lt  input  1  comparator result, 1 when cmp_a < cmp_b; combinational from cmp_a/cmp_b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_min  output  WIDTH  burst minimum
out_max  output  WIDTH  burst maximum
out_count  output  CNT_W  elements in burst, saturating

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=ACCEPT, first=1, in_ready=1, out_valid=0, out_min=0, out_max=0, out_count=0, cmp_a=0, cmp_b=0, hold=0, hold_last=0.
- Reset mid-operation: a burst in progress is discarded; the pending result (if any) is dropped; no partial output.
- States: ACCEPT, CMP_MIN, CMP_MAX, DONE.
- in_ready=1 only in ACCEPT. A handshake is in_valid&in_ready.
- ACCEPT handshake with first=1:
  - out_min<=in_data, out_max<=in_data, out_count<=1, first<=0.
  - Next state is DONE if in_last, else ACCEPT.
  - No compare is performed.
- ACCEPT handshake with first=0:
  - hold<=in_data, hold_last<=in_last.
  - out_count increments, saturating at 2^CNT_W-1.
  - cmp_a<=in_data, cmp_b<=out_min.
  - Next state CMP_MIN.
- CMP_MIN:
  - If cmp_lt, out_min<=hold.
  - cmp_a<=out_max, cmp_b<=hold.
  - Next state CMP_MAX.
- CMP_MAX:
  - If cmp_lt, out_max<=hold.
  - cmp_a<=0, cmp_b<=0.
  - Next state DONE if hold_last, else ACCEPT.
- Equal values never update min or max (strict less-than).
- Throughput: first element 1 cycle; each later element 3 cycles (ACCEPT, CMP_MIN, CMP_MAX).
- DONE:
  - out_valid=1; out_min, out_max, out_count held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid<=0, first<=1, next state ACCEPT.
  - Result registers keep their values until the next burst's first element overwrites them.
- Latency: out_valid rises 1 cycle after the handshake of a single-element burst, or 3 cycles after the last handshake otherwise.
- out_ready while out_valid=0 is ignored. in_valid outside ACCEPT is not consumed; in_data/in_last must be held by the producer.
- cmp_a/cmp_b change only on clock edges; cmp_lt is sampled one cycle after operands are registered.

Optional Feature:
- Macro: MINMAX_SIGNED_EN.
- Defined: operands are two's complement. The MSB of both cmp_a and cmp_b is inverted at the output port, so the unsigned comparator yields a signed result. Internal registers and out_min/out_max carry the true, uninverted values.
- Undefined: unsigned ordering; cmp_a/cmp_b equal the internal operand registers.

Test Plan:
- Single element 0x0000_0042 with in_last=1 -> out_valid 1 cycle later; min=max=0x42, count=1.
- Burst 5,3,9,3,7 (last on 7), out_ready=1 -> min=3, max=9, count=5. out_valid rises 3 cycles after last handshake. in_ready low during each CMP_MIN/CMP_MAX.
- Burst 0x7FFF_FFFF, 0x8000_0000 -> unsigned: min=0x7FFF_FFFF, max=0x8000_0000. With MINMAX_SIGNED_EN: min=0x8000_0000, max=0x7FFF_FFFF, and cmp_a/cmp_b MSBs observed inverted.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. Assert out_ready -> back to ACCEPT; next burst 1,2 gives min=1, max=2, count=2.
- Assert rst_n=0 during CMP_MIN of the second element -> next cycle state ACCEPT, out_valid=0, count=0. A following burst of 4 gives count=1.
- CNT_W=2 with a 6-element burst of all 0x10 -> count saturates at 3; min=max=0x10; no updates on equal values.
